// File: rtl/codec_cfg_pkg.sv
// Shared types and constants for the WM8731 codec configuration sequencer.
package codec_cfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BYTE0,
        S_BYTE1,
        S_BYTE2,
        S_GAP,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    // 7-bit device address 0x1A shifted left with the write bit (0) appended.
    localparam logic [7:0] C_DEV_ADDR_W = 8'h34;

    // One codec register write: 7-bit register address, 9-bit register value.
    typedef struct packed {
        logic [6:0] reg_addr;
        logic [8:0] reg_data;
    } entry_t;

    localparam int unsigned C_TABLE_LEN = 10;

    // Bring-up order: reset, power up, input/output levels, paths,
    // audio format, sample rate, then activate the digital interface last.
    localparam entry_t C_INIT_TABLE [C_TABLE_LEN] = '{
        '{reg_addr: 7'h0F, reg_data: 9'h000},  // reset
        '{reg_addr: 7'h06, reg_data: 9'h000},  // power: all blocks on
        '{reg_addr: 7'h00, reg_data: 9'h017},  // left line in, 0 dB
        '{reg_addr: 7'h01, reg_data: 9'h017},  // right line in, 0 dB
        '{reg_addr: 7'h02, reg_data: 9'h079},  // left headphone, 0 dB
        '{reg_addr: 7'h04, reg_data: 9'h012},  // analog path: DAC select, line in
        '{reg_addr: 7'h05, reg_data: 9'h000},  // digital path: no mute
        '{reg_addr: 7'h07, reg_data: 9'h002},  // format: I2S, 16 bit, slave
        '{reg_addr: 7'h08, reg_data: 9'h000},  // sample rate: normal mode
        '{reg_addr: 7'h09, reg_data: 9'h001}   // activate interface
    };

    // Table lookup; indices beyond the table return an all-zero entry.
    function automatic entry_t init_entry(input logic [7:0] idx);
        entry_t e;
        e = '0;
        if (idx < 8'(C_TABLE_LEN)) begin
            e = C_INIT_TABLE[idx[3:0]];
        end
        return e;
    endfunction

endpackage

// File: rtl/codec_cfg_seq.sv
// Walks the codec init table, issuing one 3-byte I2C write per entry through
// an external byte engine, with NACK-driven retries and an idle gap after
// every transaction.
module codec_cfg_seq
    import codec_cfg_pkg::*;
#(
    parameter int unsigned C_NUM_REGS   = 10,
    parameter logic [15:0] C_GAP_CYCLES = 16'd512,
    parameter int unsigned C_MAX_RETRY  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       cfg_done,
    output logic       cfg_err,
    output logic [7:0] err_index,
    output logic       eng_go,
    output logic       eng_rnw,
    output logic [7:0] eng_wdata,
    input  logic       eng_done,
    input  logic       eng_ack
);

    state_t      state_reg,     state_next;
    logic [7:0]  index_reg,     index_next;
    logic [7:0]  retry_reg,     retry_next;
    logic [15:0] gap_cnt_reg,   gap_cnt_next;
    logic        ack_seen_reg,  ack_seen_next;
    logic        nack_flag_reg, nack_flag_next;
    logic        eng_go_reg,    eng_go_next;
    logic [7:0]  eng_wdata_reg, eng_wdata_next;
    logic        busy_reg,      busy_next;
    logic        cfg_done_reg,  cfg_done_next;
    logic        cfg_err_reg,   cfg_err_next;
    logic [7:0]  err_index_reg, err_index_next;

    entry_t cur_entry;
    assign cur_entry = init_entry(index_reg);

    // Next-state and next-output logic; outputs are derived from the state
    // being entered so that every output leaves the block from a flop.
    always_comb begin
        state_next     = state_reg;
        index_next     = index_reg;
        retry_next     = retry_reg;
        gap_cnt_next   = gap_cnt_reg;
        nack_flag_next = nack_flag_reg;
        eng_wdata_next = eng_wdata_reg;
        cfg_done_next  = cfg_done_reg;
        cfg_err_next   = cfg_err_reg;
        err_index_next = err_index_reg;

        // The ACK pulse follows the done pulse of the same byte, so a
        // coincident pair is treated as an acknowledged byte.
        if (eng_ack) begin
            ack_seen_next = 1'b1;
        end else if (eng_done) begin
            ack_seen_next = 1'b0;
        end else begin
            ack_seen_next = ack_seen_reg;
        end

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    index_next     = '0;
                    retry_next     = '0;
                    cfg_done_next  = 1'b0;
                    cfg_err_next   = 1'b0;
                    eng_wdata_next = C_DEV_ADDR_W;
                    state_next     = S_BYTE0;
                end
            end
            S_BYTE0: begin
                if (eng_done) begin
                    eng_wdata_next = cur_entry[15:8];
                    state_next     = S_BYTE1;
                end
            end
            S_BYTE1: begin
                if (eng_done) begin
                    nack_flag_next = nack_flag_reg | ~ack_seen_reg;
                    eng_wdata_next = cur_entry[7:0];
                    state_next     = S_BYTE2;
                end
            end
            S_BYTE2: begin
                if (eng_done) begin
                    nack_flag_next = nack_flag_reg | ~ack_seen_reg;
                    gap_cnt_next   = C_GAP_CYCLES - 16'd1;
                    state_next     = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt_reg == 16'd0) begin
                    // The last byte's ACK has long arrived by now.
                    nack_flag_next = nack_flag_reg | ~ack_seen_reg;
                    state_next     = S_CHECK;
                end else begin
                    gap_cnt_next = gap_cnt_reg - 16'd1;
                end
            end
            S_CHECK: begin
                if (!nack_flag_reg && index_reg == 8'(C_NUM_REGS - 1)) begin
                    cfg_done_next = 1'b1;
                    state_next    = S_DONE;
                end else if (!nack_flag_reg) begin
                    index_next     = index_reg + 8'd1;
                    retry_next     = '0;
                    eng_wdata_next = C_DEV_ADDR_W;
                    state_next     = S_BYTE0;
                end else if (retry_reg < 8'(C_MAX_RETRY)) begin
                    retry_next     = retry_reg + 8'd1;
                    eng_wdata_next = C_DEV_ADDR_W;
                    state_next     = S_BYTE0;
                end else begin
                    err_index_next = index_reg;
                    cfg_err_next   = 1'b1;
                    state_next     = S_ERROR;
                end
            end
            S_DONE:  state_next = S_IDLE;
            S_ERROR: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        // A fresh attempt starts with a clean NACK history.
        if (state_next == S_BYTE0 && state_reg != S_BYTE0) begin
            nack_flag_next = 1'b0;
        end

        eng_go_next = (state_next == S_BYTE0) || (state_next == S_BYTE1) ||
                      (state_next == S_BYTE2);
        busy_next   = !((state_next == S_IDLE) || (state_next == S_DONE) ||
                        (state_next == S_ERROR));
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            index_reg     <= '0;
            retry_reg     <= '0;
            gap_cnt_reg   <= '0;
            ack_seen_reg  <= 1'b0;
            nack_flag_reg <= 1'b0;
            eng_go_reg    <= 1'b0;
            eng_wdata_reg <= 8'h00;
            busy_reg      <= 1'b0;
            cfg_done_reg  <= 1'b0;
            cfg_err_reg   <= 1'b0;
            err_index_reg <= '0;
        end else begin
            state_reg     <= state_next;
            index_reg     <= index_next;
            retry_reg     <= retry_next;
            gap_cnt_reg   <= gap_cnt_next;
            ack_seen_reg  <= ack_seen_next;
            nack_flag_reg <= nack_flag_next;
            eng_go_reg    <= eng_go_next;
            eng_wdata_reg <= eng_wdata_next;
            busy_reg      <= busy_next;
            cfg_done_reg  <= cfg_done_next;
            cfg_err_reg   <= cfg_err_next;
            err_index_reg <= err_index_next;
        end
    end

    assign eng_go    = eng_go_reg;
    assign eng_rnw   = 1'b0;
    assign eng_wdata = eng_wdata_reg;
    assign busy      = busy_reg;
    assign cfg_done  = cfg_done_reg;
    assign cfg_err   = cfg_err_reg;
    assign err_index = err_index_reg;

endmodule

// File: tb/tb_codec_cfg_seq.sv
// Scoreboard bench: a pass-level reference model plans the NACK pattern and
// the expected byte stream, a byte-engine model replays the plan, and a
// monitor checks bytes, gap lengths and end-of-pass flags.
module tb_codec_cfg_seq;

    localparam int NUM   = 3;
    localparam int GAP   = 20;
    localparam int MAXR  = 3;
    localparam int BIT   = 2;
    localparam int LIMIT = 6000;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       cfg_done;
    logic       cfg_err;
    logic [7:0] err_index;
    logic       eng_go;
    logic       eng_rnw;
    logic [7:0] eng_wdata;
    logic       eng_done;
    logic       eng_ack;

    always #5 clk = ~clk;

    codec_cfg_seq #(
        .C_NUM_REGS  (NUM),
        .C_GAP_CYCLES(16'(GAP)),
        .C_MAX_RETRY (MAXR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err),
        .err_index(err_index),
        .eng_go   (eng_go),
        .eng_rnw  (eng_rnw),
        .eng_wdata(eng_wdata),
        .eng_done (eng_done),
        .eng_ack  (eng_ack)
    );

    // Expected register words, {addr[6:0], data[8:0]} written out as hex.
    logic [15:0] tbl [10] = '{16'h1E00, 16'h0C00, 16'h0017, 16'h0217, 16'h0479,
                              16'h0812, 16'h0A00, 16'h0E02, 16'h1000, 16'h1201};

    typedef struct {
        bit         done;
        bit         err;
        logic [7:0] eidx;
    } outcome_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q [$];
    bit         plan_q [$];
    outcome_t   out_q [$];
    logic [7:0] model_eidx = 8'h00;
    logic [7:0] cur_byte = 8'h00;
    bit         abort_pass = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // NACK decision for byte b of attempt att on entry idx.
    function automatic bit decide(input int mode, input int idx, input int att, input int b);
        case (mode)
            0:       return ($urandom_range(0, 7) == 0);
            2:       return (idx == 1 && att == 0 && b == 2);
            3:       return (idx == 0);
            default: return 1'b0;
        endcase
    endfunction

    // Reference model of a whole pass: push expected bytes, the engine's
    // ACK plan and the final flags.
    task automatic plan_pass(input int mode);
        int         idx;
        int         att;
        bit         any;
        bit         nb;
        logic [7:0] v;
        logic [15:0] w;
        outcome_t   o;
        idx = 0;
        att = 0;
        o.done = 1'b0;
        o.err  = 1'b0;
        forever begin
            any = 1'b0;
            w = tbl[idx];
            for (int b = 0; b < 3; b++) begin
                v = (b == 0) ? 8'h34 : (b == 1) ? w[15:8] : w[7:0];
                exp_q.push_back(v);
                nb = decide(mode, idx, att, b);
                plan_q.push_back(nb);
                any |= nb;
            end
            if (!any) begin
                if (idx == NUM - 1) begin
                    o.done = 1'b1;
                    break;
                end
                idx++;
                att = 0;
            end else if (att < MAXR) begin
                att++;
            end else begin
                o.err = 1'b1;
                model_eidx = 8'(idx);
                break;
            end
        end
        o.eidx = model_eidx;
        out_q.push_back(o);
    endtask

    // Byte engine model: 8 data bits, done at the start of the ACK bit,
    // ACK pulse inside the ACK bit, then continue or STOP on eng_go.
    task automatic etick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_transaction();
        bit more;
        bit nack;
        more = 1'b1;
        while (more) begin
            cur_byte = eng_wdata;
            nack = (plan_q.size() > 0) ? plan_q.pop_front() : 1'b0;
            for (int i = 0; i < 8 * BIT; i++) begin
                etick();
                if (rst) return;
            end
            eng_done = 1'b1;
            etick();
            eng_done = 1'b0;
            if (!nack) eng_ack = 1'b1;
            etick();
            eng_ack = 1'b0;
            for (int i = 1; i < BIT; i++) etick();
            if (rst) return;
            more = eng_go;
        end
        for (int i = 0; i < BIT; i++) etick();
    endtask

    initial begin
        eng_done = 1'b0;
        eng_ack  = 1'b0;
        forever begin
            etick();
            if (eng_go && !rst) run_transaction();
        end
    end

    // Monitor: bytes on every done pulse, eng_go low-time between
    // transactions, and flags whenever a pass ends.
    logic [7:0] mon_exp;
    outcome_t   mon_o;
    bit         prev_busy = 1'b0;
    bit         prev_go = 1'b0;
    bit         counting = 1'b0;
    int         low_cnt = 0;

    always @(negedge clk) begin
        if (eng_done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL byte: got %02h, expected no byte", cur_byte);
            end else begin
                mon_exp = exp_q.pop_front();
                $display("byte: wdata=%02h expected=%02h", cur_byte, mon_exp);
                check("byte", 32'(cur_byte), 32'(mon_exp));
                check("rnw", 32'(eng_rnw), 32'd0);
            end
        end

        if (!busy) begin
            counting = 1'b0;
        end else if (prev_go && !eng_go) begin
            counting = 1'b1;
            low_cnt  = 1;
        end else if (counting && !eng_go) begin
            low_cnt++;
        end else if (counting && eng_go) begin
            check("gap_len", 32'(low_cnt), 32'(GAP + 1));
            counting = 1'b0;
        end

        if (prev_busy && !busy && !abort_pass) begin
            if (out_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pass_end: got end of pass, expected none");
            end else begin
                mon_o = out_q.pop_front();
                $display("pass end: done=%0d err=%0d err_index=%0d", cfg_done, cfg_err, err_index);
                check("cfg_done", 32'(cfg_done), 32'(mon_o.done));
                check("cfg_err", 32'(cfg_err), 32'(mon_o.err));
                check("err_index", 32'(err_index), 32'(mon_o.eidx));
                check("bytes_left", 32'(exp_q.size()), 32'd0);
            end
        end
        prev_busy = busy;
        prev_go   = eng_go;
    end

    task automatic mtick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_pass(input int mode, input bit poke);
        int cyc;
        plan_pass(mode);
        mtick();
        start = 1'b1;
        mtick();
        start = 1'b0;
        check("busy_rise", 32'(busy), 32'd1);
        cyc = 0;
        while (busy && cyc < LIMIT) begin
            mtick();
            cyc++;
            if (poke && busy && $urandom_range(0, 15) == 0) begin
                start = 1'b1;
                mtick();
                start = 1'b0;
                cyc++;
            end
        end
        if (cyc >= LIMIT) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pass_timeout: busy still %0d after %0d cycles, expected 0", busy, cyc);
        end
        repeat (3) mtick();
    endtask

    initial begin
        int c;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) mtick();
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_go", 32'(eng_go), 32'd0);
        check("rst_wdata", 32'(eng_wdata), 32'd0);
        check("rst_done", 32'(cfg_done), 32'd0);
        check("rst_err", 32'(cfg_err), 32'd0);
        check("rst_eidx", 32'(err_index), 32'd0);
        mtick();
        rst = 1'b0;
        repeat (2) mtick();

        run_pass(1, 1'b0);   // all ACK
        run_pass(2, 1'b0);   // entry 1 NACKs once on its last byte
        run_pass(3, 1'b0);   // entry 0 always NACKs
        run_pass(1, 1'b1);   // start pulses while busy

        // Reset while the register-address byte is in flight.
        plan_pass(1);
        mtick();
        start = 1'b1;
        mtick();
        start = 1'b0;
        c = 0;
        while (!eng_done && c < 500) begin
            mtick();
            c++;
        end
        if (c >= 500) begin
            n_cmp++;
            n_bad++;
            $display("FAIL first_done: no eng_done after %0d cycles, expected one", c);
        end
        repeat (6) mtick();
        abort_pass = 1'b1;
        rst = 1'b1;
        mtick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_go", 32'(eng_go), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(cfg_done), 32'd0);
        check("mid_rst_err", 32'(cfg_err), 32'd0);
        check("mid_rst_eidx", 32'(err_index), 32'd0);
        exp_q.delete();
        plan_q.delete();
        out_q.delete();
        model_eidx = 8'h00;
        repeat (4 * BIT) mtick();
        abort_pass = 1'b0;

        run_pass(1, 1'b0);   // full pass after reset

        for (int p = 0; p < 20; p++) begin
            run_pass(0, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/codec_cfg_seq.md
CODEC_CFG_SEQ -- requirements
Module: codec_cfg_seq

Interface
REQ-001 Parameters:
- C_NUM_REGS, default 10, number of codec register writes in the init table.
- C_GAP_CYCLES, default 16'd512, idle clk cycles after each transaction; SHALL exceed one full I2C bit time plus STOP time.
- C_MAX_RETRY, default 3, retries per entry after a NACK.
REQ-002 Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins the configuration pass.
- busy  out  1  high while a pass is running.
- cfg_done  out  1  sticky; set when all entries are written with ACK.
- cfg_err  out  1  sticky; set when an entry exhausts its retries.
- err_index  out  8  table index of the failing entry.
- eng_go  out  1  byte-engine go/continue.
- eng_rnw  out  1  byte-engine direction; constant 0 (write only).
- eng_wdata  out  8  byte presented to the engine.
- eng_done  in  1  one-cycle pulse when the engine enters the ACK phase of a byte.
- eng_ack  in  1  one-cycle pulse when the slave drove ACK low.
REQ-003 Reset rst is synchronous and active-high; clock is clk.

Function
REQ-004 Each table entry SHALL be 16 bits, {reg_addr[6:0], reg_data[8:0]}, sent as a 3-byte write: C_DEV_ADDR_W (8'h34), entry[15:8], entry[7:0].
REQ-005 FSM states: S_IDLE, S_BYTE0, S_BYTE1, S_BYTE2, S_GAP, S_CHECK, S_DONE, S_ERROR.
REQ-006 S_IDLE: outputs idle. A start pulse SHALL clear index, retry count, cfg_done and cfg_err, then go to S_BYTE0 on the next clk.
REQ-007 S_BYTE0:
- eng_go=1, eng_wdata=C_DEV_ADDR_W.
- On eng_done, SHALL go to S_BYTE1 with eng_wdata=entry[15:8] in the same registered update, so the new byte is valid before the engine's ACK bit ends.
REQ-008 S_BYTE1: on eng_done, SHALL go to S_BYTE2 with eng_wdata=entry[7:0].
REQ-009 S_BYTE2: on eng_done, SHALL deassert eng_go (registered, next cycle) and go to S_GAP, so the engine issues STOP after the ACK bit.
REQ-010 NACK tracking:
- ack_seen is cleared on every eng_done and set by eng_ack.
- On eng_done in S_BYTE1/S_BYTE2 and on gap-counter expiry, nack_flag |= ~ack_seen.
- nack_flag is cleared on entering S_BYTE0.
REQ-011 S_GAP: a 16-bit counter loads C_GAP_CYCLES-1 on entry and decrements to 0; at 0 it goes to S_CHECK. eng_go=0 throughout.
REQ-012 S_CHECK (one cycle):
- !nack_flag and index==C_NUM_REGS-1: go to S_DONE.
- !nack_flag otherwise: index++, retry cleared, go to S_BYTE0.
- nack_flag and retry<C_MAX_RETRY: retry++, same index, go to S_BYTE0.
- nack_flag otherwise: err_index=index, go to S_ERROR.
REQ-013 S_DONE sets cfg_done and S_ERROR sets cfg_err; both set busy=0 and return to S_IDLE next cycle. The flags hold until the next start or rst.
REQ-014 busy=1 in every state except S_IDLE, S_DONE and S_ERROR.
REQ-015 A start pulse while busy=1 SHALL be ignored.
REQ-016 eng_done outside S_BYTE0..S_BYTE2 SHALL be ignored.
REQ-017 All outputs SHALL be registered. eng_rnw is tied to 0.
REQ-018 The index counter SHALL be 8 bits; C_NUM_REGS SHALL be in 1..255.

Reset
REQ-019 On rst: state=S_IDLE, eng_go=0, eng_wdata=8'h00, busy=0, cfg_done=0, cfg_err=0, err_index=0, counters cleared.
REQ-020 rst mid-transaction SHALL drop eng_go in the next cycle. The engine is reset by the same rst, so no STOP is guaranteed.

Structure
REQ-021 Package codec_cfg_pkg SHALL hold: the state enum, C_DEV_ADDR_W, the entry typedef, and the constant init-table array (WM8731 reset, power, format, sample rate, active).
REQ-022 The block is a single module with no sub-modules. The gap counter is inline.

Verification
REQ-023 Directed scenarios, run against a byte-engine model (done every 9 bit times, ack pulse per byte):
- All ACK, C_NUM_REGS=2: start -> six eng_done cycles with wdata 34,h(e0),l(e0),34,h(e1),l(e1); cfg_done=1; busy low.
- Entry 1 NACKs once on byte 2: entry 1 is resent exactly once, then cfg_done=1, cfg_err=0.
- Entry 0 always NACKs, C_MAX_RETRY=3: 4 attempts, then cfg_err=1, err_index=0, cfg_done=0.
- start pulsed during busy: no restart, and the sequence order is unchanged.
- rst asserted in S_BYTE1: next cycle eng_go=0, busy=0, all flags 0; a later start runs a full pass.
- Gap check: eng_go stays low for exactly C_GAP_CYCLES+1 cycles between transactions.
